// File: rtl/dcache_controller.sv
// ============================================================================
// Module   : dcache_controller
// Brief    : Direct-mapped write-back data cache, 8 blocks x 4 bytes, with a
//            stall-based miss path (victim write-back, then block fetch).
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [7:0]  r_valid;
  logic [7:0]  r_dirty;
  logic [2:0]  r_tag  [8];
  logic [31:0] r_data [8];

  logic [2:0]  w_tag;
  logic [2:0]  w_index;
  logic [1:0]  w_offset;
  logic [4:0]  w_bit_pos;
  logic        w_hit;
  logic        w_req;
  logic        w_write_hit;
  logic        w_fill;

  assign w_tag       = ADDRESS[7:5];
  assign w_index     = ADDRESS[4:2];
  assign w_offset    = ADDRESS[1:0];
  assign w_bit_pos   = {w_offset, 3'b000};
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_req       = READ | WRITE;
  assign w_write_hit = (r_state == IDLE) && WRITE && w_hit;
  assign w_fill      = (r_state == FETCH) && !MEM_BUSYWAIT;

  // Read data comes straight from the indexed entry so hits need no stall.
  assign READDATA    = r_data[w_index][w_bit_pos +: 8];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < 8; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state <= w_next_state;
      if (w_fill) begin
        r_data[w_index]  <= MEM_READDATA;
        r_tag[w_index]   <= w_tag;
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if (w_write_hit) begin
        r_data[w_index][w_bit_pos +: 8] <= WRITEDATA;
        r_dirty[w_index]                <= 1'b1;
      end
    end
  end

  // Memory-side outputs are masked by RESET so an abandoned request drops at once.
  always_comb begin
    w_next_state  = r_state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          BUSYWAIT = 1'b1;
          if (r_valid[w_index] && r_dirty[w_index]) begin
            w_next_state = WRITEBACK;
          end else begin
            w_next_state = FETCH;
          end
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {r_tag[w_index], w_index};
        MEM_WRITEDATA = r_data[w_index];
        if (!MEM_BUSYWAIT) begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[7:2];
        if (!MEM_BUSYWAIT) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (RESET) begin
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// ============================================================================
// Module   : tb_dcache_controller
// Brief    : Directed self-checking bench for dcache_controller with a
//            fixed-latency block memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_controller;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int checks   = 0;
  int failures = 0;

  dcache_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: busy for 5 cycles of a held request, ready on the 6th.
  localparam int C_LAT = 5;
  logic [3:0]  r_mem_cnt = '0;
  logic [5:0]  r_wb_addr = '0;
  logic [31:0] r_wb_data = '0;

  function automatic logic [31:0] mem_block(input logic [5:0] a);
    case (a)
      6'h00:   return 32'h44332211;
      6'h08:   return 32'h88776655;
      6'h11:   return 32'hDDCCBBAA;
      6'h18:   return 32'h0C0B0A09;
      default: return {4{2'b00, a}};
    endcase
  endfunction

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (int'(r_mem_cnt) < C_LAT);
  assign MEM_READDATA = MEM_READ ? mem_block(MEM_ADDRESS) : 32'h0;

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) begin
      if (!MEM_BUSYWAIT) begin
        r_mem_cnt <= '0;
        if (MEM_WRITE) begin
          r_wb_addr <= MEM_ADDRESS;
          r_wb_data <= MEM_WRITEDATA;
        end
      end else begin
        r_mem_cnt <= r_mem_cnt + 4'd1;
      end
    end else begin
      r_mem_cnt <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after the request is driven; returns in the first non-stall cycle.
  int          m_n;
  logic        m_rd, m_wr, m_both, m_bad_wd;
  logic [5:0]  m_rd_addr, m_wr_addr;
  logic [31:0] m_wr_data;

  task automatic run_miss();
    m_n = 0; m_rd = 0; m_wr = 0; m_both = 0; m_bad_wd = 0;
    m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0;
    #1;
    while (BUSYWAIT === 1'b1 && m_n < 100) begin
      if (MEM_READ && MEM_WRITE) m_both = 1;
      if (!MEM_WRITE && MEM_WRITEDATA !== 32'h0) m_bad_wd = 1;
      if (MEM_READ)  begin m_rd = 1; m_rd_addr = MEM_ADDRESS; end
      if (MEM_WRITE) begin m_wr = 1; m_wr_addr = MEM_ADDRESS; m_wr_data = MEM_WRITEDATA; end
      @(negedge CLK); #1;
      m_n++;
    end
  endtask

  initial begin
    RESET = 1; READ = 1; WRITE = 0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    @(negedge CLK); #1;
    check("busy_in_reset", {31'b0, BUSYWAIT}, 32'h0);
    @(negedge CLK);
    RESET = 0; READ = 0; #1;
    check("rst_mem_rd", {31'b0, MEM_READ}, 32'h0);
    check("rst_mem_wr", {31'b0, MEM_WRITE}, 32'h0);
    check("rst_mem_addr", {26'b0, MEM_ADDRESS}, 32'h0);
    check("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
    check("rst_readdata", {24'b0, READDATA}, 32'h0);

    // Clean read miss at 0x00
    @(negedge CLK); READ = 1; ADDRESS = 8'h00;
    run_miss();
    check("clean_busy_cycles", m_n, 7);
    check("clean_saw_rd", {31'b0, m_rd}, 32'h1);
    check("clean_no_wr", {31'b0, m_wr}, 32'h0);
    check("clean_rd_addr", {26'b0, m_rd_addr}, 32'h00);
    check("clean_readdata", {24'b0, READDATA}, 32'h11);
    check("clean_valid", {31'b0, dut.r_valid[0]}, 32'h1);
    check("clean_dirty", {31'b0, dut.r_dirty[0]}, 32'h0);

    // Read hit at 0x03
    @(negedge CLK); ADDRESS = 8'h03; #1;
    check("hit_busy", {31'b0, BUSYWAIT}, 32'h0);
    check("hit_readdata", {24'b0, READDATA}, 32'h44);
    check("hit_no_mem", {30'b0, MEM_READ, MEM_WRITE}, 32'h0);

    // Write hit 0xAB at 0x01
    @(negedge CLK); READ = 0; WRITE = 1; ADDRESS = 8'h01; WRITEDATA = 8'hAB; #1;
    check("whit_busy", {31'b0, BUSYWAIT}, 32'h0);
    @(negedge CLK); WRITE = 0; READ = 1; #1;
    check("whit_readback", {24'b0, READDATA}, 32'hAB);
    check("whit_dirty", {31'b0, dut.r_dirty[0]}, 32'h1);

    // Dirty read miss at 0x20
    @(negedge CLK); ADDRESS = 8'h20;
    run_miss();
    check("dirty_busy_cycles", m_n, 13);
    check("dirty_saw_wr", {31'b0, m_wr}, 32'h1);
    check("dirty_wr_addr", {26'b0, m_wr_addr}, 32'h00);
    check("dirty_wr_data", m_wr_data, 32'h4433AB11);
    check("dirty_rd_addr", {26'b0, m_rd_addr}, 32'h08);
    check("dirty_no_overlap", {31'b0, m_both}, 32'h0);
    check("dirty_wdata_idle0", {31'b0, m_bad_wd}, 32'h0);
    check("dirty_mem_got", r_wb_data, 32'h4433AB11);
    check("dirty_readdata", {24'b0, READDATA}, 32'h55);
    check("dirty_new_tag", {29'b0, dut.r_tag[0]}, 32'h1);
    check("dirty_now_clean", {31'b0, dut.r_dirty[0]}, 32'h0);

    // Write miss 0x5A at 0x45, clean (invalid) victim
    @(negedge CLK); READ = 0; WRITE = 1; ADDRESS = 8'h45; WRITEDATA = 8'h5A;
    run_miss();
    check("wmiss_busy_cycles", m_n, 7);
    check("wmiss_no_wr", {31'b0, m_wr}, 32'h0);
    check("wmiss_rd_addr", {26'b0, m_rd_addr}, 32'h11);
    @(negedge CLK); WRITE = 0; READ = 1; #1;
    check("wmiss_readback", {24'b0, READDATA}, 32'h5A);
    check("wmiss_dirty", {31'b0, dut.r_dirty[1]}, 32'h1);

    // Reset during the third FETCH cycle of a miss at 0x60
    @(negedge CLK); ADDRESS = 8'h60; #1;
    check("rmid_idle_busy", {31'b0, BUSYWAIT}, 32'h1);
    @(negedge CLK); #1;
    check("rmid_fetch_rd", {31'b0, MEM_READ}, 32'h1);
    check("rmid_fetch_addr", {26'b0, MEM_ADDRESS}, 32'h18);
    @(negedge CLK);
    @(negedge CLK); RESET = 1; READ = 0; #1;
    check("rmid_busy_in_reset", {31'b0, BUSYWAIT}, 32'h0);
    @(negedge CLK); #1;
    check("rmid_rd_dropped", {31'b0, MEM_READ}, 32'h0);
    check("rmid_readdata0", {24'b0, READDATA}, 32'h0);
    RESET = 0;
    @(negedge CLK); READ = 1; ADDRESS = 8'h60;
    run_miss();
    check("rmid_remiss_cycles", m_n, 7);
    check("rmid_remiss_addr", {26'b0, m_rd_addr}, 32'h18);
    check("rmid_remiss_data", {24'b0, READDATA}, 32'h09);
    @(negedge CLK); READ = 0; #1;
    check("idle_mem_addr0", {26'b0, MEM_ADDRESS}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back data cache controller between the CPU's load/store path and the 32-bit-block data memory. It serves byte reads and writes from an 8-entry cache in the same cycle on a hit. On a miss it asserts BUSYWAIT to stall the PC and register-file write, writes back a dirty victim, fetches the missing block, then completes the access.

## Interface
Parameters:
- none (geometry fixed: 8 blocks × 4 bytes, 8-bit byte address)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- READ  in  1  CPU byte-load request
- WRITE  in  1  CPU byte-store request
- ADDRESS  in  8  byte address: tag[7:5], index[4:2], offset[1:0]
- WRITEDATA  in  8  store data
- READDATA  out  8  load data; valid when READ=1 and BUSYWAIT=0
- BUSYWAIT  out  1  CPU stall; CPU holds READ/WRITE/ADDRESS/WRITEDATA stable while high
- MEM_READ  out  1  block fetch request
- MEM_WRITE  out  1  block write-back request
- MEM_ADDRESS  out  6  block address {tag,index}
- MEM_WRITEDATA  out  32  victim block, byte 0 in [7:0]
- MEM_READDATA  in  32  fetched block, byte 0 in [7:0]
- MEM_BUSYWAIT  in  1  memory busy; memory holds it high (combinationally from request) until its final cycle

## Operation
- Storage per entry: valid, dirty, tag[2:0], data[31:0].
- Hit = valid[index] && tag[index]==ADDRESS[7:5].
- Request = READ|WRITE. If both are high, WRITE takes priority; this combination is illegal from the CPU.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE:
  - No request: BUSYWAIT=0.
  - Read hit: BUSYWAIT=0; READDATA = data[index] byte[offset] (combinational).
  - Write hit: BUSYWAIT=0; at the edge, data[index] byte[offset] ← WRITEDATA and dirty ← 1.
  - Miss with valid && dirty victim: BUSYWAIT=1; next state WRITEBACK.
  - Miss otherwise: BUSYWAIT=1; next state FETCH.
- WRITEBACK:
  - Outputs: MEM_WRITE=1, MEM_ADDRESS={tag[index],index}, MEM_WRITEDATA=data[index], BUSYWAIT=1.
  - At the edge where MEM_BUSYWAIT=0: go to FETCH.
- FETCH:
  - Outputs: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2], BUSYWAIT=1.
  - At the edge where MEM_BUSYWAIT=0: data[index] ← MEM_READDATA, tag ← ADDRESS[7:5], valid ← 1, dirty ← 0; go to IDLE.
- After FETCH returns to IDLE, the pending access re-evaluates as a hit and completes normally; a write miss therefore becomes a write hit.
- MEM_READ and MEM_WRITE are never high together. Both are low in IDLE.
- MEM_WRITEDATA = 0 when MEM_WRITE=0. MEM_ADDRESS = 0 in IDLE.
- READDATA is driven from the indexed entry in every state; it is only meaningful when BUSYWAIT=0.

## Timing
- Reset (RESET=1 at a rising edge):
  - state ← IDLE; every valid, dirty, tag and data bit ← 0.
  - During and after reset: MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - BUSYWAIT=0 while RESET is high.
  - READDATA=0 after reset until the first fill.
- Reset mid-miss: the in-flight memory request drops on the next cycle and no fill occurs. Memory must tolerate an abandoned request.
- Hit latency: 0 stall cycles. Read data is valid in the request cycle; write data is committed at the closing edge.
- Clean miss with memory busy for L cycles: BUSYWAIT high for L+2 cycles (1 IDLE + L+1 FETCH). The access completes in the following cycle.
- Dirty miss: BUSYWAIT high for Lw+Lr+3 cycles.
- Memory handshake:
  - A request is held constant until a rising edge sees request=1 and MEM_BUSYWAIT=0.
  - MEM_READDATA is sampled on that edge.
  - Request lines deassert or change on the following cycle.
- Request deasserted while in WRITEBACK or FETCH: the current memory transaction still completes, then the FSM returns to IDLE.

## Test plan
- Reset, then READ @0x00 with L=5 → BUSYWAIT high for 7 cycles, MEM_READ with MEM_ADDRESS=0x00; memory returns 0x44332211 → READDATA=0x11, entry 0 valid and clean.
- After fill, READ @0x03 → hit with BUSYWAIT=0 in the same cycle, READDATA=0x44; no MEM_* activity.
- WRITE 0xAB @0x01 (hit) → no stall; subsequent READ @0x01 returns 0xAB and entry 0 is dirty.
- READ @0x20 (same index, tag 1), L=5 for both transactions:
  - MEM_WRITE with MEM_ADDRESS=0x00 and MEM_WRITEDATA=0x4433AB11.
  - Then MEM_READ with MEM_ADDRESS=0x08.
  - BUSYWAIT high for 13 cycles; entry 0 ends with tag=1, clean.
- WRITE 0x5A @0x45 (miss, clean victim) → FETCH with MEM_ADDRESS=0x11, then the byte is written; READ @0x45 returns 0x5A and the entry is dirty.
- RESET asserted during the third FETCH cycle → MEM_READ=0 next cycle; a later READ of the same address misses again.
